// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Brings the board PLL out of reset, waits for a debounced lock, then releases
// the per-domain reset requests one after another. Lock loss and soft reset
// restart the sequence. Repeated lock timeouts end in FAULT until cleared.
// Everything runs on refclk; downstream domains resynchronise rst_req_n.
//
// Optional feature macro: PLL_SEQ_LOCKLOSS_CNT_EN
//   defined   : lockloss_count counts lock-loss exits from RELEASE/RUN
//   undefined : lockloss_count is tied to 0
//
// state       | meaning
// ------------+-----------------------------------------------------------
// RESET_PLL   | pll_rst high for PLL_RST_CYCLES, all domains held in reset
// WAIT_LOCK   | pll_rst low, waiting for LOCK_STABLE_CYCLES of steady lock
// RELEASE     | releasing rst_req_n bits, STAGGER_CYCLES apart, bit 0 first
// RUN         | all domains released, ready high
// FAULT       | too many failed attempts; pll held in reset until clear_fault

module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 32,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRIES         = 7,
  parameter int STAGGER_CYCLES      = 16,
  parameter int NUM_DOMAINS         = 3
) (
  input  logic                   refclk,
  input  logic                   rst_n,
  input  logic                   pll_locked,
  input  logic                   soft_rst,
  input  logic                   clear_fault,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] rst_req_n,
  output logic                   ready,
  output logic                   fault,
  output logic [7:0]             retry_count,
  output logic [7:0]             lockloss_count
);

  localparam int PR_W = $clog2(PLL_RST_CYCLES + 1);
  localparam int ST_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TO_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int SG_W = $clog2(STAGGER_CYCLES + 1);

  localparam logic [PR_W-1:0] PR_LAST = PR_W'(PLL_RST_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [SG_W-1:0] SG_LAST = SG_W'(STAGGER_CYCLES - 1);
  localparam logic [7:0]      RETRY_LIMIT = 8'(MAX_RETRIES);
  localparam logic [NUM_DOMAINS-1:0] DOM_ONE = NUM_DOMAINS'(1);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_RELEASE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t          state;
  logic [1:0]      rst_sync;
  logic            run_en;
  logic            lock_meta;
  logic            lock_s;
  logic [PR_W-1:0] pr_cnt;
  logic [ST_W-1:0] stable_cnt;
  logic [TO_W-1:0] timeout_cnt;
  logic [SG_W-1:0] stagger_cnt;
  logic [7:0]      retry_inc;

  assign run_en    = rst_sync[1];
  assign retry_inc = (retry_count == 8'hFF) ? 8'hFF : retry_count + 8'd1;

  // Synchronise rst_n deassertion so the FSM leaves reset cleanly on refclk.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  // Two-flop synchroniser for the asynchronous PLL lock flag.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  // Sequencing FSM with registered outputs and its timers.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_RESET_PLL;
      pr_cnt      <= '0;
      stable_cnt  <= '0;
      timeout_cnt <= '0;
      stagger_cnt <= '0;
      retry_count <= 8'd0;
      pll_rst     <= 1'b1;
      rst_req_n   <= '0;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else if (run_en) begin
      if (state != S_FAULT && soft_rst) begin
        state     <= S_RESET_PLL;
        pr_cnt    <= '0;
        pll_rst   <= 1'b1;
        rst_req_n <= '0;
        ready     <= 1'b0;
      end else begin
        case (state)
          S_RESET_PLL: begin
            if (pr_cnt == PR_LAST) begin
              state       <= S_WAIT_LOCK;
              pll_rst     <= 1'b0;
              stable_cnt  <= '0;
              timeout_cnt <= '0;
            end else begin
              pr_cnt <= pr_cnt + PR_W'(1);
            end
          end

          S_WAIT_LOCK: begin
            if (lock_s && stable_cnt == ST_LAST) begin
              state       <= S_RELEASE;
              stagger_cnt <= '0;
            end else if (timeout_cnt == TO_LAST) begin
              retry_count <= retry_inc;
              pll_rst     <= 1'b1;
              pr_cnt      <= '0;
              if (retry_inc >= RETRY_LIMIT) begin
                state <= S_FAULT;
                fault <= 1'b1;
              end else begin
                state <= S_RESET_PLL;
              end
            end else begin
              timeout_cnt <= timeout_cnt + TO_W'(1);
              stable_cnt  <= lock_s ? stable_cnt + ST_W'(1) : '0;
            end
          end

          S_RELEASE: begin
            if (!lock_s) begin
              state     <= S_RESET_PLL;
              pr_cnt    <= '0;
              pll_rst   <= 1'b1;
              rst_req_n <= '0;
            end else if (rst_req_n[NUM_DOMAINS-1]) begin
              state       <= S_RUN;
              ready       <= 1'b1;
              retry_count <= 8'd0;
            end else if (!rst_req_n[0] || stagger_cnt == SG_LAST) begin
              rst_req_n   <= (rst_req_n << 1) | DOM_ONE;
              stagger_cnt <= '0;
            end else begin
              stagger_cnt <= stagger_cnt + SG_W'(1);
            end
          end

          S_RUN: begin
            if (!lock_s) begin
              state     <= S_RESET_PLL;
              pr_cnt    <= '0;
              pll_rst   <= 1'b1;
              rst_req_n <= '0;
              ready     <= 1'b0;
            end
          end

          S_FAULT: begin
            if (clear_fault) begin
              state       <= S_RESET_PLL;
              pr_cnt      <= '0;
              retry_count <= 8'd0;
              fault       <= 1'b0;
            end
          end

          default: begin
            state     <= S_RESET_PLL;
            pr_cnt    <= '0;
            pll_rst   <= 1'b1;
            rst_req_n <= '0;
            ready     <= 1'b0;
            fault     <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef PLL_SEQ_LOCKLOSS_CNT_EN
  logic       lockloss_evt;
  logic [7:0] lockloss_q;

  // A soft reset in the same cycle owns the exit, so it is not a lock loss.
  assign lockloss_evt = run_en && !soft_rst && !lock_s &&
                        (state == S_RELEASE || state == S_RUN);

  // Saturating count of lock-loss restarts, cleared by leaving FAULT.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)
      lockloss_q <= 8'd0;
    else if (run_en && state == S_FAULT && clear_fault)
      lockloss_q <= 8'd0;
    else if (lockloss_evt && lockloss_q != 8'hFF)
      lockloss_q <= lockloss_q + 8'd1;
  end

  assign lockloss_count = lockloss_q;
`else
  assign lockloss_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: a table of bring-up checkpoints,
// hand-written corner-case sequences, and randomized lock/soft-reset stimulus,
// all compared against a phase/timestamp reference model kept here.
module tb_pll_reset_sequencer;

  localparam int PRC = 4;
  localparam int LSC = 8;
  localparam int LTC = 50;
  localparam int MR  = 2;
  localparam int SC  = 3;
  localparam int ND  = 3;

  localparam int P_RST = 0;
  localparam int P_WAIT = 1;
  localparam int P_REL = 2;
  localparam int P_RUN = 3;
  localparam int P_FLT = 4;

  logic          refclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pll_locked = 1'b0;
  logic          soft_rst = 1'b0;
  logic          clear_fault = 1'b0;
  logic          pll_rst;
  logic [ND-1:0] rst_req_n;
  logic          ready;
  logic          fault;
  logic [7:0]    retry_count;
  logic [7:0]    lockloss_count;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  int m_phase, m_start, m_last_low, m_cyc, m_en, m_l1, m_l2, m_retry, m_ll;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(PRC), .LOCK_STABLE_CYCLES(LSC), .LOCK_TIMEOUT_CYCLES(LTC),
    .MAX_RETRIES(MR), .STAGGER_CYCLES(SC), .NUM_DOMAINS(ND)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked),
    .soft_rst(soft_rst), .clear_fault(clear_fault), .pll_rst(pll_rst),
    .rst_req_n(rst_req_n), .ready(ready), .fault(fault),
    .retry_count(retry_count), .lockloss_count(lockloss_count)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_RST; m_l1 = 0; m_l2 = 0; m_en = 0;
    m_retry = 0; m_ll = 0; m_start = m_cyc; m_last_low = m_cyc;
  endtask

  task automatic enter(input int p);
    m_phase = p; m_start = m_cyc; m_last_low = m_cyc;
  endtask

  // expected rst_req_n from time spent in the phase
  function automatic logic [ND-1:0] exp_req();
    logic [ND-1:0] msk;
    int e, n;
    msk = '0;
    if (m_phase == P_RUN) msk = '1;
    else if (m_phase == P_REL) begin
      e = m_cyc - m_start;
      n = (e < 1) ? 0 : ((e - 1) / SC + 1);
      if (n > ND) n = ND;
      for (int i = 0; i < n; i++) msk[i] = 1'b1;
    end
    return msk;
  endfunction

  task automatic model_step();
    int ls, e;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_cyc++;
    ls = m_l2; m_l2 = m_l1; m_l1 = int'(pll_locked);
    if (m_en < 2) begin
      m_en++;
      m_start = m_cyc;
      return;
    end
    e = m_cyc - m_start;
    if (m_phase == P_FLT) begin
      if (clear_fault) begin
        enter(P_RST); m_retry = 0; m_ll = 0;
      end
    end else if (soft_rst) begin
      enter(P_RST);
    end else begin
      case (m_phase)
        P_RST: if (e == PRC) enter(P_WAIT);
        P_WAIT: begin
          if (ls == 0) m_last_low = m_cyc;
          if (ls == 1 && m_cyc - m_last_low == LSC) enter(P_REL);
          else if (e == LTC) begin
            m_retry = (m_retry < 255) ? m_retry + 1 : 255;
            if (m_retry >= MR) enter(P_FLT);
            else enter(P_RST);
          end
        end
        P_REL: begin
          if (ls == 0) begin enter(P_RST); m_ll++; end
          else if (e == (ND - 1) * SC + 2) begin enter(P_RUN); m_retry = 0; end
        end
        P_RUN: if (ls == 0) begin enter(P_RST); m_ll++; end
        default: enter(P_RST);
      endcase
    end
  endtask

  function automatic int exp_ll();
`ifdef PLL_SEQ_LOCKLOSS_CNT_EN
    return m_ll;
`else
    return 0;
`endif
  endfunction

  task automatic check_model();
    chk("pll_rst", int'(pll_rst), (m_phase == P_RST || m_phase == P_FLT) ? 1 : 0);
    chk("rst_req_n", int'(rst_req_n), int'(exp_req()));
    chk("ready", int'(ready), (m_phase == P_RUN) ? 1 : 0);
    chk("fault", int'(fault), (m_phase == P_FLT) ? 1 : 0);
    chk("retry_count", int'(retry_count), m_retry);
    chk("lockloss_count", int'(lockloss_count), exp_ll());
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
    model_step();
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pll_locked = 1'b0; soft_rst = 1'b0; clear_fault = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    int            n;
    logic          lk;
    logic          sr;
    logic          e_prst;
    logic [ND-1:0] e_req;
    logic          e_rdy;
  } vec_t;

  vec_t tbl[12];
  int   mode;

  initial begin
    // bring-up checkpoints, cumulative ticks after reset release
    tbl[0]  = '{5, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0};  // t=5
    tbl[1]  = '{1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0};  // t=6 WAIT_LOCK
    tbl[2]  = '{8, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0};  // t=14 RELEASE entry
    tbl[3]  = '{1, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0};  // t=15
    tbl[4]  = '{2, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0};  // t=17
    tbl[5]  = '{1, 1'b1, 1'b0, 1'b0, 3'b011, 1'b0};  // t=18
    tbl[6]  = '{3, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0};  // t=21
    tbl[7]  = '{1, 1'b1, 1'b0, 1'b0, 3'b111, 1'b1};  // t=22 RUN
    tbl[8]  = '{4, 1'b1, 1'b0, 1'b0, 3'b111, 1'b1};  // t=26
    tbl[9]  = '{1, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0};  // t=27 soft reset
    tbl[10] = '{3, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0};  // t=30
    tbl[11] = '{1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0};  // t=31 WAIT_LOCK

    m_cyc = 0;
    do_reset();
    chk("reset_pll_rst", int'(pll_rst), 1);
    chk("reset_rst_req_n", int'(rst_req_n), 0);
    chk("reset_ready", int'(ready), 0);
    chk("reset_fault", int'(fault), 0);

    for (int i = 0; i < 12; i++) begin
      pll_locked = tbl[i].lk;
      soft_rst   = tbl[i].sr;
      repeat (tbl[i].n) tick();
      chk("tbl_pll_rst", int'(pll_rst), int'(tbl[i].e_prst));
      chk("tbl_rst_req_n", int'(rst_req_n), int'(tbl[i].e_req));
      chk("tbl_ready", int'(ready), int'(tbl[i].e_rdy));
      chk("tbl_retry", int'(retry_count), 0);
    end
    soft_rst = 1'b0;

    // lock toggling with a 5-cycle period never debounces; one timeout
    do_reset();
    for (int t = 1; t <= 60; t++) begin
      pll_locked = ((t % 5) < 3);
      tick();
      if (t == 55) begin
        chk("glitch_pre_retry", int'(retry_count), 0);
        chk("glitch_pre_pll_rst", int'(pll_rst), 0);
      end
      if (t == 56) begin
        chk("glitch_retry", int'(retry_count), 1);
        chk("glitch_pll_rst_on", int'(pll_rst), 1);
      end
      if (t == 59) chk("glitch_pll_rst_hold", int'(pll_rst), 1);
      if (t == 60) chk("glitch_pll_rst_off", int'(pll_rst), 0);
    end

    // lock never arrives: two timeouts to FAULT, soft_rst ignored, clear_fault
    do_reset();
    for (int t = 1; t <= 116; t++) begin
      pll_locked  = 1'b0;
      soft_rst    = (t == 112);
      clear_fault = (t == 115);
      tick();
      if (t == 110) begin
        chk("flt_fault", int'(fault), 1);
        chk("flt_retry", int'(retry_count), 2);
        chk("flt_pll_rst", int'(pll_rst), 1);
        chk("flt_rst_req_n", int'(rst_req_n), 0);
      end
      if (t == 113) chk("flt_soft_ignored", int'(fault), 1);
      if (t == 115) begin
        chk("clr_fault", int'(fault), 0);
        chk("clr_retry", int'(retry_count), 0);
        chk("clr_pll_rst", int'(pll_rst), 1);
      end
    end
    soft_rst = 1'b0; clear_fault = 1'b0;

    // one-cycle lock drop in RUN, full re-sequence
    do_reset();
    for (int t = 1; t <= 46; t++) begin
      pll_locked = (t != 23);
      tick();
      if (t == 22) chk("ll_run_ready", int'(ready), 1);
      if (t == 24) chk("ll_still_ready", int'(ready), 1);
      if (t == 25) begin
        chk("ll_ready_drop", int'(ready), 0);
        chk("ll_req_drop", int'(rst_req_n), 0);
        chk("ll_pll_rst", int'(pll_rst), 1);
      end
      if (t == 44) chk("ll_resequence_pre", int'(ready), 0);
      if (t == 45) begin
        chk("ll_resequence_ready", int'(ready), 1);
`ifdef PLL_SEQ_LOCKLOSS_CNT_EN
        chk("ll_count", int'(lockloss_count), 1);
`else
        chk("ll_count", int'(lockloss_count), 0);
`endif
      end
    end

    // soft_rst in RELEASE with retry=1, then async reset mid-RELEASE
    do_reset();
    for (int t = 1; t <= 87; t++) begin
      pll_locked = (t >= 57);
      soft_rst   = (t == 70);
      tick();
      if (t == 69) begin
        chk("sr_pre_req", int'(rst_req_n), 1);
        chk("sr_pre_retry", int'(retry_count), 1);
      end
      if (t == 70) begin
        chk("sr_req", int'(rst_req_n), 0);
        chk("sr_pll_rst", int'(pll_rst), 1);
        chk("sr_retry_kept", int'(retry_count), 1);
      end
      if (t == 87) chk("arst_pre_req", int'(rst_req_n), 3);
    end
    soft_rst = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_pll_rst", int'(pll_rst), 1);
    chk("arst_rst_req_n", int'(rst_req_n), 0);
    chk("arst_ready", int'(ready), 0);
    chk("arst_fault", int'(fault), 0);
    chk("arst_retry", int'(retry_count), 0);
    chk("arst_lockloss", int'(lockloss_count), 0);
    model_reset();

    // randomized lock behaviour, soft resets and fault clears
    do_reset();
    mode = 0;
    for (int t = 0; t < 4000; t++) begin
      if (t % 64 == 0) mode = int'($urandom_range(0, 3));
      case (mode)
        0: pll_locked = 1'b1;
        1: pll_locked = 1'b0;
        2: pll_locked = ($urandom_range(0, 1) == 1);
        default: pll_locked = ($urandom_range(0, 39) != 0);
      endcase
      soft_rst    = ($urandom_range(0, 149) == 0);
      clear_fault = (m_phase == P_FLT) ? ($urandom_range(0, 19) == 0)
                                       : ($urandom_range(0, 99) == 0);
      tick();
    end
    soft_rst = 1'b0; clear_fault = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
